// File: rtl/if_id_inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of {pc, inst} packets with flush.
// Optional zero-latency fetch-to-decode path is enabled by defining IFQ_BYPASS_EN.
module if_id_inst_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int BUS_W = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             IF_to_ID_Valid,
  input  logic [BUS_W-1:0] IF_to_ID_Bus,
  output logic             ID_Allow_in,
  output logic             Q_to_ID_Valid,
  output logic [BUS_W-1:0] Q_to_ID_Bus,
  input  logic             ID_Ready,
  input  logic             flush,
  output logic [PTR_W:0]   q_count
);

  logic [BUS_W-1:0] mem_q [DEPTH];
  logic [BUS_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic full;
  logic empty;
  logic bypass;
  logic push;
  logic pop;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == (PTR_W+1)'(DEPTH));
`ifdef IFQ_BYPASS_EN
    // Decode takes the fetch packet directly; it never occupies an entry.
    bypass = empty & IF_to_ID_Valid & ID_Ready & ~flush;
`else
    bypass = 1'b0;
`endif
    push = IF_to_ID_Valid & ~full & ~flush & ~bypass;
    pop  = ~empty & ID_Ready & ~flush;
  end

  always_comb begin
    ID_Allow_in = ~full;
    q_count     = count_q;
    if (!empty) begin
      Q_to_ID_Valid = 1'b1;
      Q_to_ID_Bus   = mem_q[rd_ptr_q];
    end else begin
      Q_to_ID_Valid = 1'b0;
      Q_to_ID_Bus   = '0;
`ifdef IFQ_BYPASS_EN
      if (IF_to_ID_Valid && !flush) begin
        Q_to_ID_Valid = 1'b1;
        Q_to_ID_Bus   = IF_to_ID_Bus;
      end
`endif
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) mem_d[wr_ptr_q] = IF_to_ID_Bus;
  end

  // Storage needs no reset: the output is forced to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_if_id_inst_queue.sv
// Directed bench for if_id_inst_queue: vector table for fill/drain/wrap/push-pop/flush,
// plus hand sequences for bypass latency and asynchronous reset.
module tb_if_id_inst_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int BUS_W = 64;

  logic             clk = 1'b0;
  logic             resetn;
  logic             IF_to_ID_Valid;
  logic [BUS_W-1:0] IF_to_ID_Bus;
  logic             ID_Allow_in;
  logic             Q_to_ID_Valid;
  logic [BUS_W-1:0] Q_to_ID_Bus;
  logic             ID_Ready;
  logic             flush;
  logic [PTR_W:0]   q_count;

  int checks = 0;
  int errors = 0;

  if_id_inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .BUS_W(BUS_W)) dut (
    .clk(clk),
    .resetn(resetn),
    .IF_to_ID_Valid(IF_to_ID_Valid),
    .IF_to_ID_Bus(IF_to_ID_Bus),
    .ID_Allow_in(ID_Allow_in),
    .Q_to_ID_Valid(Q_to_ID_Valid),
    .Q_to_ID_Bus(Q_to_ID_Bus),
    .ID_Ready(ID_Ready),
    .flush(flush),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        rdy;
    logic        fl;
    logic        e_allow;
    logic        e_qv;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic logic [63:0] pkt(input logic [31:0] pc);
    return {pc, pc ^ 32'h0BAD_F00D};
  endfunction

  task automatic add(input logic v, input logic [31:0] pc, input logic rdy, input logic fl,
                     input logic e_allow, input logic e_qv, input logic [31:0] e_pc,
                     input logic [2:0] e_cnt);
    vec_t t;
    t.v = v; t.pc = pc; t.rdy = rdy; t.fl = fl;
    t.e_allow = e_allow; t.e_qv = e_qv; t.e_pc = e_pc; t.e_cnt = e_cnt;
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic e_allow, input logic e_qv,
                           input logic [63:0] e_bus, input logic [2:0] e_cnt);
    chk({tag, ".allow"}, 64'(ID_Allow_in), 64'(e_allow));
    chk({tag, ".qvalid"}, 64'(Q_to_ID_Valid), 64'(e_qv));
    chk({tag, ".qbus"}, Q_to_ID_Bus, e_bus);
    chk({tag, ".qcount"}, 64'(q_count), 64'(e_cnt));
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    @(negedge clk);
    IF_to_ID_Valid = v;
    IF_to_ID_Bus   = v ? pkt(pc) : 64'h0;
    ID_Ready       = rdy;
    flush          = fl;
    #1;
  endtask

  localparam logic [31:0] A0 = 32'h1c00_0000;

  function automatic logic [31:0] pa(input int k);
    return A0 + 32'(4 * k);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Expected outputs are those seen just before the clock edge that applies the inputs.
    add(0, 0,     0, 0, 1, 0, 0,     0);
    add(1, pa(0), 0, 0, 1, 0, 0,     0);
    add(1, pa(1), 0, 0, 1, 1, pa(0), 1);
    add(1, pa(2), 0, 0, 1, 1, pa(0), 2);
    add(1, pa(3), 0, 0, 1, 1, pa(0), 3);
    add(1, pa(4), 0, 0, 0, 1, pa(0), 4);
    add(1, pa(4), 1, 0, 0, 1, pa(0), 4);
    add(1, pa(4), 1, 0, 1, 1, pa(1), 3);
    add(1, pa(5), 1, 0, 1, 1, pa(2), 3);
    add(0, 0,     1, 0, 1, 1, pa(3), 3);
    add(0, 0,     1, 0, 1, 1, pa(4), 2);
    add(1, pa(6), 0, 0, 1, 1, pa(5), 1);
    add(1, pa(7), 1, 0, 1, 1, pa(5), 2);
    add(0, 0,     0, 0, 1, 1, pa(6), 2);
    add(1, pa(8), 0, 0, 1, 1, pa(6), 2);
    add(1, pa(9), 1, 1, 1, 1, pa(6), 3);
    add(0, 0,     0, 0, 1, 0, 0,     0);
    add(1, pa(10),0, 1, 1, 0, 0,     0);
    add(1, pa(11),0, 0, 1, 0, 0,     0);
    add(0, 0,     0, 0, 1, 1, pa(11),1);
    add(0, 0,     1, 0, 1, 1, pa(11),1);
    add(0, 0,     0, 0, 1, 0, 0,     0);

    resetn = 1'b0;
    IF_to_ID_Valid = 1'b0; IF_to_ID_Bus = '0; ID_Ready = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_out("reset", 1, 0, 64'h0, 0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].v, vq[i].pc, vq[i].rdy, vq[i].fl);
      check_out($sformatf("vec%0d", i), vq[i].e_allow, vq[i].e_qv,
                vq[i].e_qv ? pkt(vq[i].e_pc) : 64'h0, vq[i].e_cnt);
      $display("vec%0d v=%0b pc=%h rdy=%0b fl=%0b -> allow=%0b qv=%0b bus=%h cnt=%0d",
               i, vq[i].v, vq[i].pc, vq[i].rdy, vq[i].fl,
               ID_Allow_in, Q_to_ID_Valid, Q_to_ID_Bus, q_count);
    end

    // Empty queue, decode ready, one packet from fetch.
    drive(1, 32'h1c00_0100, 1, 0);
`ifdef IFQ_BYPASS_EN
    check_out("byp.same", 1, 1, pkt(32'h1c00_0100), 0);
    drive(0, 0, 1, 0);
    check_out("byp.next", 1, 0, 64'h0, 0);
`else
    check_out("byp.same", 1, 0, 64'h0, 0);
    drive(0, 0, 1, 0);
    check_out("byp.next", 1, 1, pkt(32'h1c00_0100), 1);
    drive(0, 0, 0, 0);
    check_out("byp.drained", 1, 0, 64'h0, 0);
`endif
    $display("bypass sequence done qv=%0b cnt=%0d", Q_to_ID_Valid, q_count);

    // Asynchronous reset with three entries queued.
    drive(1, 32'h1c00_0200, 0, 0);
    drive(1, 32'h1c00_0204, 0, 0);
    drive(1, 32'h1c00_0208, 0, 0);
    drive(0, 0, 0, 0);
    check_out("rst.pre", 1, 1, pkt(32'h1c00_0200), 3);
    #1;
    resetn = 1'b0;
    #1;
    check_out("rst.async", 1, 0, 64'h0, 0);
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 0, 1, 0);
    check_out("rst.after", 1, 0, 64'h0, 0);
    $display("reset sequence done qv=%0b cnt=%0d", Q_to_ID_Valid, q_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
